// File: rtl/led_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_seq_ctrl                                                 |
// | Description : 4-LED pattern sequencer with request/ack mode switching.     |
// |               Optional 25% PWM dimming when LED_SEQ_DIM_EN is defined.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module led_seq_ctrl #(
    parameter logic [22:0] TSTEP = 23'd5_000_000
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Mode_Req,
    input  logic [1:0] Mode_Sel,
    input  logic       Pause,
    output logic       Mode_Ack,
    output logic       Step_Tick,
    output logic [3:0] LED_Out
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } state_t;

    localparam logic [22:0] c_cnt_last = TSTEP - 23'd1;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [3:0]  r_index;
    logic [22:0] r_count;

    logic        w_cnt_last;
    logic [3:0]  w_pattern;
    logic        w_lit_en;

    function automatic logic [3:0] f_last_index(input logic [1:0] mode);
        logic [3:0] last;
        case (mode)
            2'd0:    last = 4'd3;
            2'd1:    last = 4'd5;
            2'd2:    last = 4'd1;
            default: last = 4'd15;
        endcase
        return last;
    endfunction

    function automatic logic [3:0] f_decode(input logic [1:0] mode, input logic [3:0] idx);
        logic [3:0] pat;
        pat = 4'b0000;
        case (mode)
            2'd0: pat = 4'b0001 << idx[1:0];
            2'd1: begin
                case (idx)
                    4'd0:    pat = 4'b0001;
                    4'd1:    pat = 4'b0010;
                    4'd2:    pat = 4'b0100;
                    4'd3:    pat = 4'b1000;
                    4'd4:    pat = 4'b0100;
                    4'd5:    pat = 4'b0010;
                    default: pat = 4'b0000;
                endcase
            end
            2'd2:    pat = idx[0] ? 4'b0000 : 4'b1111;
            default: pat = idx;
        endcase
        return pat;
    endfunction

    assign w_cnt_last = (r_count == c_cnt_last);
    assign w_pattern  = f_decode(r_mode, r_index);

`ifdef LED_SEQ_DIM_EN
    logic [1:0] r_pwm;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_pwm <= 2'd0;
        end else begin
            r_pwm <= r_pwm + 2'd1;
        end
    end

    assign w_lit_en = (r_pwm == 2'd0);
`else
    assign w_lit_en = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state   <= ST_RUN;
            r_mode    <= 2'd0;
            r_index   <= 4'd0;
            r_count   <= 23'd0;
            LED_Out   <= 4'b0000;
            Mode_Ack  <= 1'b0;
            Step_Tick <= 1'b0;
        end else begin
            Mode_Ack  <= 1'b0;
            Step_Tick <= 1'b0;
            LED_Out   <= (r_state == ST_SWITCH) ? 4'b0000 : (w_pattern & {4{w_lit_en}});

            case (r_state)
                ST_RUN: begin
                    // Acceptance takes priority over a coincident step advance
                    if (Mode_Req) begin
                        r_mode   <= Mode_Sel;
                        r_index  <= 4'd0;
                        r_count  <= 23'd0;
                        Mode_Ack <= 1'b1;
                        r_state  <= ST_SWITCH;
                    end else if (!Pause) begin
                        if (w_cnt_last) begin
                            r_count   <= 23'd0;
                            r_index   <= (r_index == f_last_index(r_mode)) ? 4'd0 : r_index + 4'd1;
                            Step_Tick <= 1'b1;
                        end else begin
                            r_count <= r_count + 23'd1;
                        end
                    end
                end
                ST_SWITCH: begin
                    if (w_cnt_last) begin
                        r_count <= 23'd0;
                        r_index <= 4'd0;
                        r_state <= ST_RUN;
                    end else begin
                        r_count <= r_count + 23'd1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_led_seq_ctrl                                              |
// | Description : Randomized self-checking bench for led_seq_ctrl (TSTEP=4).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_led_seq_ctrl;

    localparam logic [22:0] TSTEP = 23'd4;
    localparam int          C_T   = 4;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       Mode_Req;
    logic [1:0] Mode_Sel;
    logic       Pause;
    logic       Mode_Ack;
    logic       Step_Tick;
    logic [3:0] LED_Out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: pattern tables plus elapsed-cycle bookkeeping per step/switch
    logic [3:0] pat [4][16];
    int         pat_len [4];
    bit         m_switch;
    int         m_mode, m_pos, m_cyc, m_pwm;
    logic [3:0] e_led;
    logic       e_ack, e_tick;

    led_seq_ctrl #(.TSTEP(TSTEP)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Mode_Req  (Mode_Req),
        .Mode_Sel  (Mode_Sel),
        .Pause     (Pause),
        .Mode_Ack  (Mode_Ack),
        .Step_Tick (Step_Tick),
        .LED_Out   (LED_Out)
    );

    always #5 CLK = ~CLK;

    task automatic model_edge();
        logic [3:0] led_now;
        if (!RST_n) begin
            m_switch = 1'b0; m_mode = 0; m_pos = 0; m_cyc = 0; m_pwm = 0;
            e_led = 4'b0000; e_ack = 1'b0; e_tick = 1'b0;
            return;
        end
        led_now = m_switch ? 4'b0000 : pat[m_mode][m_pos];
`ifdef LED_SEQ_DIM_EN
        if (m_pwm != 0) led_now = 4'b0000;
`endif
        m_pwm  = (m_pwm + 1) % 4;
        e_ack  = 1'b0;
        e_tick = 1'b0;
        if (!m_switch && Mode_Req) begin
            e_ack = 1'b1; m_mode = int'(Mode_Sel); m_pos = 0; m_cyc = 0; m_switch = 1'b1;
        end else if (m_switch) begin
            m_cyc++;
            if (m_cyc == C_T) begin m_switch = 1'b0; m_cyc = 0; m_pos = 0; end
        end else if (!Pause) begin
            m_cyc++;
            if (m_cyc == C_T) begin
                m_cyc = 0; m_pos = (m_pos + 1) % pat_len[m_mode]; e_tick = 1'b1;
            end
        end
        e_led = led_now;
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        RST_n = 1'b0; Mode_Req = 1'b0; Mode_Sel = 2'd0; Pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (LED_Out !== 4'b0000 || Mode_Ack !== 1'b0 || Step_Tick !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state: LED=%b Ack=%b Tick=%b required 0000/0/0", LED_Out, Mode_Ack, Step_Tick);
            end
        end
        RST_n = 1'b1;
        cycle();
        n_checks++;
        if (LED_Out !== 4'b0001 || Mode_Ack !== 1'b0 || Step_Tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: LED=%b Ack=%b Tick=%b required 0001/0/0", LED_Out, Mode_Ack, Step_Tick);
        end
    endtask

    task automatic test_run_mode0();
        int ticks = 0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (Step_Tick === 1'b1) ticks++;
            n_checks++;
            if (LED_Out !== e_led || Mode_Ack !== e_ack || Step_Tick !== e_tick) begin
                n_errors++;
                $display("FAIL run_mode0 c%0d: LED=%b Ack=%b Tick=%b required %b/%b/%b",
                         i, LED_Out, Mode_Ack, Step_Tick, e_led, e_ack, e_tick);
            end
        end
        n_checks++;
        if (ticks != 6) begin
            n_errors++;
            $display("FAIL run_mode0_ticks: got %0d required 6", ticks);
        end
    endtask

    task automatic test_mode_switch(input logic [1:0] sel, input int ncyc);
        Mode_Req = 1'b1; Mode_Sel = sel;
        for (int i = 0; i < ncyc; i++) begin
            cycle();
            if (Mode_Ack === 1'b1) Mode_Req = 1'b0;
            n_checks++;
            if (LED_Out !== e_led || Mode_Ack !== e_ack || Step_Tick !== e_tick) begin
                n_errors++;
                $display("FAIL mode_switch%0d c%0d: LED=%b Ack=%b Tick=%b required %b/%b/%b",
                         sel, i, LED_Out, Mode_Ack, Step_Tick, e_led, e_ack, e_tick);
            end
        end
        if (Mode_Req) begin
            n_checks++; n_errors++;
            $display("FAIL mode_switch%0d_ack: no Mode_Ack within %0d cycles", sel, ncyc);
            Mode_Req = 1'b0;
        end
    endtask

    task automatic test_pause();
        logic [3:0] held;
        int guard = 0;
        while (!(!m_switch && m_cyc == 1) && guard < 20) begin cycle(); guard++; end
        #1;
        held = LED_Out;
        Pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_checks++;
            if (LED_Out !== held || Step_Tick !== 1'b0 || LED_Out !== e_led || Step_Tick !== e_tick) begin
                n_errors++;
                $display("FAIL pause_hold c%0d: LED=%b Tick=%b required %b/0", i, LED_Out, Step_Tick, held);
            end
        end
        Pause = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_checks++;
            if (LED_Out !== e_led || Mode_Ack !== e_ack || Step_Tick !== e_tick) begin
                n_errors++;
                $display("FAIL pause_resume c%0d: LED=%b Ack=%b Tick=%b required %b/%b/%b",
                         i, LED_Out, Mode_Ack, Step_Tick, e_led, e_ack, e_tick);
            end
        end
        // Resume completes the interrupted step: tick lands C_T-1 cycles after unpause
    endtask

    task automatic test_req_on_last();
        int guard = 0;
        int acks  = 0;
        while (!(!m_switch && m_cyc == C_T - 1) && guard < 20) begin cycle(); guard++; end
        if (guard >= 20) begin
            n_checks++; n_errors++;
            $display("FAIL req_on_last_align: could not reach last count");
        end
        Mode_Req = 1'b1; Mode_Sel = 2'($urandom_range(3, 0));
        cycle();
        n_checks++;
        if (Mode_Ack !== 1'b1 || Step_Tick !== 1'b0 || LED_Out !== e_led) begin
            n_errors++;
            $display("FAIL req_on_last: Ack=%b Tick=%b LED=%b required 1/0/%b", Mode_Ack, Step_Tick, LED_Out, e_led);
        end
        for (int i = 0; i < C_T; i++) begin
            cycle();
            if (Mode_Ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 0) begin
            n_errors++;
            $display("FAIL req_in_switch: acks=%0d required 0", acks);
        end
        cycle();
        n_checks++;
        if (Mode_Ack !== 1'b1 || Mode_Ack !== e_ack) begin
            n_errors++;
            $display("FAIL req_pending_ack: Ack=%b required 1", Mode_Ack);
        end
        Mode_Req = 1'b0;
        for (int i = 0; i < 2 * C_T + 2; i++) begin
            cycle();
            n_checks++;
            if (LED_Out !== e_led || Mode_Ack !== e_ack || Step_Tick !== e_tick) begin
                n_errors++;
                $display("FAIL req_settle c%0d: LED=%b Ack=%b Tick=%b required %b/%b/%b",
                         i, LED_Out, Mode_Ack, Step_Tick, e_led, e_ack, e_tick);
            end
        end
    endtask

    task automatic test_reset_in_switch();
        Mode_Req = 1'b1; Mode_Sel = 2'd3;
        cycle();
        Mode_Req = 1'b0;
        n_checks++;
        if (Mode_Ack !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_switch_ack: Ack=%b required 1", Mode_Ack);
        end
        cycle();
        RST_n = 1'b0;
        cycle();
        n_checks++;
        if (LED_Out !== 4'b0000 || Mode_Ack !== 1'b0 || Step_Tick !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_switch_zero: LED=%b Ack=%b Tick=%b required 0000/0/0", LED_Out, Mode_Ack, Step_Tick);
        end
        RST_n = 1'b1;
        cycle();
        n_checks++;
        if (LED_Out !== 4'b0001 || LED_Out !== e_led) begin
            n_errors++;
            $display("FAIL rst_switch_resume: LED=%b required 0001", LED_Out);
        end
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_checks++;
            if (LED_Out !== e_led || Mode_Ack !== e_ack || Step_Tick !== e_tick) begin
                n_errors++;
                $display("FAIL rst_switch_run c%0d: LED=%b Ack=%b Tick=%b required %b/%b/%b",
                         i, LED_Out, Mode_Ack, Step_Tick, e_led, e_ack, e_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            Pause = ($urandom_range(3, 0) == 0);
            RST_n = ($urandom_range(149, 0) != 0);
            if (!Mode_Req && $urandom_range(11, 0) == 0) begin
                Mode_Req = 1'b1; Mode_Sel = 2'($urandom_range(3, 0));
            end
            cycle();
            if (Mode_Ack === 1'b1) Mode_Req = 1'b0;
            n_checks++;
            if (LED_Out !== e_led || Mode_Ack !== e_ack || Step_Tick !== e_tick) begin
                n_errors++;
                $display("FAIL random c%0d: LED=%b Ack=%b Tick=%b required %b/%b/%b",
                         i, LED_Out, Mode_Ack, Step_Tick, e_led, e_ack, e_tick);
            end
        end
        RST_n = 1'b1; Pause = 1'b0; Mode_Req = 1'b0;
    endtask

    task automatic test_dim();
`ifdef LED_SEQ_DIM_EN
        int guard = 0;
        int lit   = 0;
        Mode_Req = 1'b1; Mode_Sel = 2'd2;
        cycle();
        Mode_Req = 1'b0;
        while (m_switch && guard < 20) begin cycle(); guard++; end
        for (int i = 0; i < C_T; i++) begin
            cycle();
            if (LED_Out === 4'b1111) lit++;
            n_checks++;
            if (LED_Out !== e_led) begin
                n_errors++;
                $display("FAIL dim c%0d: LED=%b required %b", i, LED_Out, e_led);
            end
        end
        n_checks++;
        if (lit != 1) begin
            n_errors++;
            $display("FAIL dim_duty: lit cycles=%0d required 1", lit);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            pat[0][i] = (i < 4) ? 4'(1 << i) : 4'b0000;
            pat[1][i] = (i < 4) ? 4'(1 << i) : (i < 6) ? 4'(1 << (6 - i)) : 4'b0000;
            pat[2][i] = (i == 0) ? 4'b1111 : 4'b0000;
            pat[3][i] = 4'(i);
        end
        pat_len[0] = 4; pat_len[1] = 6; pat_len[2] = 2; pat_len[3] = 16;

        test_reset();
        test_run_mode0();
        test_mode_switch(2'd1, 34);
        test_pause();
        test_req_on_last();
        test_mode_switch(2'd1, 12);
        test_reset_in_switch();
        test_random();
        test_dim();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 The block SHALL have parameter TSTEP, default 23'd5_000_000, meaning clock cycles per pattern step (100 ms at 50 MHz); legal range 2..2^23-1.
REQ-002 The block SHALL have port CLK, input, 1, the single system clock; all logic on posedge CLK.
REQ-003 The block SHALL have port RST_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port Mode_Req, input, 1, request to load a new pattern; held high until Mode_Ack.
REQ-005 The block SHALL have port Mode_Sel, input, 2, requested pattern; stable while Mode_Req is high.
REQ-006 The block SHALL have port Pause, input, 1, freezes pattern stepping while high.
REQ-007 The block SHALL have port Mode_Ack, output, 1, one-cycle pulse on request acceptance.
REQ-008 The block SHALL have port Step_Tick, output, 1, one-cycle pulse per pattern advance.
REQ-009 The block SHALL have port LED_Out, output, 4, LED drive, bit=1 lit.

Function
REQ-010 The block SHALL contain a 23-bit step counter counting 0..TSTEP-1 and wrapping to 0.
REQ-011 FSM states SHALL be RUN and SWITCH only.
REQ-012 Patterns by index SHALL be: mode 0 running 0001,0010,0100,1000; mode 1 ping-pong 0001,0010,0100,1000,0100,0010; mode 2 blink 1111,0000; mode 3 binary count 0000..1111. Each wraps to index 0 after its last entry.
REQ-013 In RUN with Pause low, when counter==TSTEP-1, the block SHALL on the next edge clear the counter, advance the index, and register Step_Tick=1 for one cycle.
REQ-014 In RUN with Pause high, the counter and index SHALL hold; Step_Tick SHALL stay 0.
REQ-015 LED_Out SHALL be a registered decode of (mode, index), one cycle after the index changes.
REQ-016 A request SHALL be accepted in RUN when Mode_Req=1, irrespective of Pause. On acceptance the block SHALL register Mode_Sel, pulse Mode_Ack one cycle, clear the counter and index, and enter SWITCH.
REQ-017 Mode_Req in SWITCH SHALL NOT be acknowledged; it remains pending until the return to RUN.
REQ-018 In SWITCH, LED_Out SHALL be 0000 and the counter SHALL run without regard to Pause. At counter==TSTEP-1 the block SHALL clear the counter and return to RUN at index 0 with no Step_Tick.
REQ-019 If acceptance coincides with counter==TSTEP-1 in RUN, acceptance SHALL win: no index advance, Step_Tick=0.
REQ-020 A request for the current mode SHALL still be accepted and SHALL restart the pattern via SWITCH.
REQ-021 Mode_Ack SHALL never be high on two consecutive cycles.

Reset
REQ-022 While RST_n=0 at a CLK edge, the block SHALL set state RUN, mode 0, index 0, counter 0, LED_Out 0000, Mode_Ack 0, Step_Tick 0.
REQ-023 On the first edge with RST_n=1, LED_Out SHALL become 0001.
REQ-024 Reset asserted mid-SWITCH or mid-step SHALL abandon the operation; a pending Mode_Req SHALL be re-evaluated only after reset is released.

Configuration
REQ-025 With macro LED_SEQ_DIM_EN defined, the block SHALL include a free-running 2-bit PWM counter (reset 0), and lit LED_Out bits SHALL be 1 only when the PWM counter==0, giving 25% duty.
REQ-026 Without LED_SEQ_DIM_EN, lit bits SHALL be steady 1 and no PWM logic SHALL be present.

Verification (TSTEP=4, LED_SEQ_DIM_EN undefined unless stated)
REQ-027 Release reset, idle inputs -> LED_Out 0001 after 1 cycle; then 0010, 0100, 1000, 0001 at 4-cycle spacing, with Step_Tick each step.
REQ-028 Mode_Req=1, Mode_Sel=1 in RUN -> Mode_Ack pulse next cycle, LED_Out 0000 for 4 cycles, then sequence 0001,0010,0100,1000,0100,0010,0001.
REQ-029 Pause=1 for 10 cycles mid-step -> LED_Out and counter frozen, no Step_Tick; resume completes the remaining count.
REQ-030 Mode_Req asserted on the counter==3 cycle -> Mode_Ack=1, Step_Tick=0, index not advanced; Mode_Req held through SWITCH -> no second Ack until the return to RUN.
REQ-031 RST_n=0 for 1 cycle during SWITCH in mode 3 -> all outputs 0, then mode 0 resumes with LED_Out 0001.
REQ-032 LED_SEQ_DIM_EN defined, mode 2 -> during the 1111 step, LED_Out=1111 on exactly 1 of every 4 cycles.
